// File: rtl/npu_host_ctrl.sv
// NPU host front end: BRAM-style port decode, weight FIFO,
// conv->fc sequencer with watchdog, abort and sticky status.
module npu_host_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 16,
    parameter int SEL_LSB     = 12,
    parameter int BUF_WORDS   = 64,
    parameter int FIFO_DEPTH  = 16,
    parameter int RES_W       = 24,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic               wea,
    input  logic [ADDR_W-1:0]  addra,
    input  logic [DATA_W-1:0]  dina,
    output logic [DATA_W-1:0]  douta,
    output logic               buf_we,
    output logic [2:0]         buf_id,
    output logic [SEL_LSB-1:0] buf_addr,
    output logic [DATA_W-1:0]  buf_wdata,
    output logic               conv_start,
    input  logic               conv_done,
    output logic               fc_start,
    input  logic               fc_done,
    input  logic [RES_W-1:0]   fc_result,
    output logic               w_valid,
    output logic [DATA_W-1:0]  w_data,
    input  logic               w_ready,
    output logic               busy,
    output logic               irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [SEL_LSB:0] BUF_LIM = (SEL_LSB + 1)'(BUF_WORDS);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        FC   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, nxt;

    logic               cap_we;
    logic [2:0]         cap_sel;
    logic [SEL_LSB-1:0] cap_idx;
    logic [DATA_W-1:0]  cap_data;

    logic [DATA_W-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [AW:0]        count;

    logic [WD_W-1:0]    wd;
    logic               done_q, aborted;
    logic               err_oob, err_ovf, err_busy, err_to;
    logic signed [RES_W-1:0] result_q;

    logic cmd_hit, cmd_start, cmd_abort, cmd_clear;
    logic buf_hit, buf_oob, buf_ok, buf_busy;
    logic push_req, push_ok, pop, full, ovf_ev;
    logic wd_hit, flush, abort_ev, to_ev, latch, start_ev, busy_ev;

    logic [2:0]         rd_sel;
    logic [SEL_LSB-1:0] rd_idx;
    logic [DATA_W-1:0]  rd_data;
    logic [DATA_W-1:0]  status_w;

    if (ADDR_W > SEL_LSB + 3) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^addra[ADDR_W-1:SEL_LSB+3];
    end

    // Decode of the write captured in the previous cycle.
    assign cmd_hit   = cap_we && (cap_sel == 3'd0) && (cap_idx == SEL_LSB'(2));
    assign cmd_start = cmd_hit && cap_data[0];
    assign cmd_abort = cmd_hit && cap_data[1];
    assign cmd_clear = cmd_hit && cap_data[2];

    assign buf_hit  = cap_we && (cap_sel != 3'd0) && (cap_sel != 3'd7);
    assign buf_oob  = buf_hit && ({1'b0, cap_idx} >= BUF_LIM);
    assign buf_ok   = buf_hit && !buf_oob && !busy;
    assign buf_busy = buf_hit && !buf_oob && busy;

    assign buf_we    = buf_ok;
    assign buf_id    = buf_ok ? cap_sel - 3'd1 : 3'd0;
    assign buf_addr  = buf_ok ? cap_idx : '0;
    assign buf_wdata = buf_ok ? cap_data : '0;

    assign busy     = (state != IDLE);
    assign full     = (count == FULL_LVL);
    assign w_valid  = (state == FC) && (count != '0);
    assign w_data   = w_valid ? mem[rd_ptr] : '0;
    assign pop      = w_valid && w_ready;
    assign push_req = cap_we && (cap_sel == 3'd7);
    assign push_ok  = push_req && (!full || pop);
    assign ovf_ev   = push_req && full && !pop;

    assign wd_hit   = (TIMEOUT_CYC != 0) && (wd == WD_LAST);
    assign start_ev = (state == IDLE) && (nxt == CONV);
    assign busy_ev  = (cmd_start && busy) || buf_busy;

    assign irq = done_q | err_oob | err_ovf | err_busy | err_to;

    // Sequencer next state; abort beats completion beats watchdog.
    always_comb begin
        nxt      = state;
        flush    = 1'b0;
        abort_ev = 1'b0;
        to_ev    = 1'b0;
        latch    = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd_start) nxt = CONV;
            end
            CONV: begin
                if (cmd_abort) begin
                    nxt      = IDLE;
                    flush    = 1'b1;
                    abort_ev = 1'b1;
                end else if (conv_done) begin
                    nxt = FC;
                end else if (wd_hit) begin
                    nxt   = IDLE;
                    flush = 1'b1;
                    to_ev = 1'b1;
                end
            end
            FC: begin
                if (cmd_abort) begin
                    nxt      = IDLE;
                    flush    = 1'b1;
                    abort_ev = 1'b1;
                end else if (fc_done) begin
                    nxt   = DONE;
                    latch = 1'b1;
                end else if (wd_hit) begin
                    nxt   = IDLE;
                    flush = 1'b1;
                    to_ev = 1'b1;
                end
            end
            DONE: begin
                nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // Capture host writes; they take effect one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_we   <= 1'b0;
            cap_sel  <= 3'd0;
            cap_idx  <= '0;
            cap_data <= '0;
        end else begin
            cap_we   <= ena && wea;
            cap_sel  <= addra[SEL_LSB+2:SEL_LSB];
            cap_idx  <= addra[SEL_LSB-1:0];
            cap_data <= dina;
        end
    end

    // State register, per-phase watchdog and start pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wd         <= '0;
            conv_start <= 1'b0;
            fc_start   <= 1'b0;
        end else begin
            state      <= nxt;
            conv_start <= start_ev;
            fc_start   <= (state == CONV) && (nxt == FC);
            if (nxt != state) wd <= '0;
            else if (busy) wd <= wd + WD_W'(1);
        end
    end

    // Weight FIFO pointers and level; flush empties it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW + 1)'(push_ok) - (AW + 1)'(pop);
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= cap_data;
    end

    // Sticky flags and result; a new event beats a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q   <= 1'b0;
            aborted  <= 1'b0;
            err_oob  <= 1'b0;
            err_ovf  <= 1'b0;
            err_busy <= 1'b0;
            err_to   <= 1'b0;
            result_q <= '0;
        end else begin
            if (state == DONE) done_q <= 1'b1;
            else if (cmd_clear || start_ev) done_q <= 1'b0;
            aborted  <= (aborted & ~cmd_clear) | abort_ev;
            err_oob  <= (err_oob & ~cmd_clear) | buf_oob;
            err_ovf  <= (err_ovf & ~cmd_clear) | ovf_ev;
            err_busy <= (err_busy & ~cmd_clear) | busy_ev;
            err_to   <= (err_to & ~cmd_clear) | to_ev;
            if (latch) result_q <= fc_result;
        end
    end

    assign rd_sel   = addra[SEL_LSB+2:SEL_LSB];
    assign rd_idx   = addra[SEL_LSB-1:0];
    assign status_w = DATA_W'({1'b0, state, 1'b0, aborted, err_to,
                               err_busy, err_ovf, err_oob, done_q, busy});

    // Host read mux; only region 0 is readable.
    always_comb begin
        rd_data = '0;
        if (rd_sel == 3'd0) begin
            case (rd_idx)
                SEL_LSB'(0): rd_data = status_w;
                SEL_LSB'(1): rd_data = DATA_W'(result_q);
                SEL_LSB'(3): rd_data = DATA_W'(count);
                default:     rd_data = '0;
            endcase
        end
    end

    // Registered read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) douta <= '0;
        else if (ena && !wea) douta <= rd_data;
    end

endmodule

// File: tb/tb_npu_host_ctrl.sv
// Self-checking bench for npu_host_ctrl: randomized host traffic
// and flows checked against a queue/flag reference model.
module tb_npu_host_ctrl;

    localparam int TO = 12;
    localparam int BW = 64;
    localparam int FD = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b0;
    logic        wea = 1'b0;
    logic [15:0] addra = '0;
    logic [31:0] dina = '0;
    logic [31:0] douta;
    logic        buf_we;
    logic [2:0]  buf_id;
    logic [11:0] buf_addr;
    logic [31:0] buf_wdata;
    logic        conv_start;
    logic        conv_done = 1'b0;
    logic        fc_start;
    logic        fc_done = 1'b0;
    logic [23:0] fc_result = '0;
    logic        w_valid;
    logic [31:0] w_data;
    logic        w_ready = 1'b0;
    logic        busy;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model
    logic [31:0] q[$];
    bit m_done, m_oob, m_ovf, m_busy, m_to, m_abt;
    logic [31:0] m_result;

    npu_host_ctrl #(
        .DATA_W(32), .ADDR_W(16), .SEL_LSB(12), .BUF_WORDS(BW),
        .FIFO_DEPTH(FD), .RES_W(24), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena), .wea(wea),
        .addra(addra), .dina(dina), .douta(douta),
        .buf_we(buf_we), .buf_id(buf_id), .buf_addr(buf_addr),
        .buf_wdata(buf_wdata), .conv_start(conv_start),
        .conv_done(conv_done), .fc_start(fc_start),
        .fc_done(fc_done), .fc_result(fc_result),
        .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
        .busy(busy), .irq(irq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_status(input int st);
        logic [2:0] s3;
        s3 = 3'(st);
        return {21'b0, s3, 1'b0, m_abt, m_to, m_busy,
                m_ovf, m_oob, m_done, st != 0};
    endfunction

    task automatic model_clear();
        m_done = 0; m_oob = 0; m_ovf = 0;
        m_busy = 0; m_to = 0; m_abt = 0;
    endtask

    task automatic wr(input logic [2:0] sel, input int idx,
                      input logic [31:0] d);
        logic [11:0] i12;
        i12 = 12'(idx);
        @(negedge clk);
        ena = 1; wea = 1; addra = {1'b0, sel, i12}; dina = d;
        @(negedge clk);
        ena = 0; wea = 0;
    endtask

    task automatic rd(input int idx, output logic [31:0] d);
        logic [11:0] i12;
        i12 = 12'(idx);
        @(negedge clk);
        ena = 1; wea = 0; addra = {4'b0, i12};
        @(negedge clk);
        ena = 0;
        d = douta;
    endtask

    task automatic wait_busy();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!busy && k < 6);
        n_cmp++;
        if (!busy) begin
            n_bad++;
            $display("FAIL wait_busy: busy=%b required 1", busy);
        end
    endtask

    task automatic run_to_fc(input int d);
        wr(3'd0, 2, 32'h1);
        m_done = 0;
        wait_busy();
        n_cmp++;
        if (conv_start !== 1'b1) begin
            n_bad++;
            $display("FAIL conv_start: got %b required 1", conv_start);
        end
        repeat (d) @(negedge clk);
        conv_done = 1;
        @(negedge clk);
        conv_done = 0;
        n_cmp++;
        if ({fc_start, busy} !== 2'b11) begin
            n_bad++;
            $display("FAIL fc_start: got %b required 11", {fc_start, busy});
        end
    endtask

    task automatic check_regs(input string tag, input int st);
        logic [31:0] v;
        rd(0, v);
        n_cmp++;
        if (v !== exp_status(st)) begin
            n_bad++;
            $display("FAIL %s status: got %h required %h",
                     tag, v, exp_status(st));
        end
        rd(3, v);
        n_cmp++;
        if (v !== 32'(q.size())) begin
            n_bad++;
            $display("FAIL %s level: got %0d required %0d",
                     tag, v, q.size());
        end
        rd(1, v);
        n_cmp++;
        if (v !== m_result) begin
            n_bad++;
            $display("FAIL %s result: got %h required %h",
                     tag, v, m_result);
        end
        n_cmp++;
        if (irq !== (m_done | m_oob | m_ovf | m_busy | m_to)) begin
            n_bad++;
            $display("FAIL %s irq: got %b", tag, irq);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, irq, buf_we, conv_start, fc_start, w_valid,
             douta, w_data, buf_wdata} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got nonzero required 0");
        end
        rst = 0;
        q.delete();
        model_clear();
        m_result = '0;
        check_regs("reset", 0);
    endtask

    task automatic test_buf_write();
        logic [2:0]  sel;
        int          idx;
        logic [31:0] d;
        bit          ok;
        for (int n = 0; n < 24; n++) begin
            if (n == 0) begin
                sel = 3'd1; idx = 5; d = 32'hA1B2C3D4;
            end else if (n == 1) begin
                sel = 3'd2; idx = BW; d = $urandom;
            end else begin
                sel = 3'($urandom_range(1, 6));
                idx = $urandom_range(0, BW + 7);
                d = $urandom;
            end
            wr(sel, idx, d);
            ok = (idx < BW);
            if (!ok) m_oob = 1;
            n_cmp++;
            if (buf_we !== ok) begin
                n_bad++;
                $display("FAIL buf_we: got %b required %b idx=%0d",
                         buf_we, ok, idx);
            end
            if (ok) begin
                n_cmp++;
                if ({buf_id, buf_addr, buf_wdata} !==
                    {sel - 3'd1, 12'(idx), d}) begin
                    n_bad++;
                    $display("FAIL buf_fields: got %h/%h/%h required %h/%h/%h",
                             buf_id, buf_addr, buf_wdata,
                             sel - 3'd1, 12'(idx), d);
                end
            end
            if (n == 0) begin
                @(negedge clk);
                n_cmp++;
                if (buf_we !== 1'b0) begin
                    n_bad++;
                    $display("FAIL buf_we_pulse: got %b required 0", buf_we);
                end
            end
        end
        check_regs("oob", 0);
        wr(3'd0, 2, 32'h4);
        model_clear();
        check_regs("oob_clear", 0);
    endtask

    task automatic test_fifo_overflow();
        logic [31:0] d;
        for (int n = 0; n < FD + 1; n++) begin
            d = $urandom;
            wr(3'd7, 0, d);
            if (q.size() < FD) q.push_back(d);
            else m_ovf = 1;
        end
        check_regs("overflow", 0);
        wr(3'd0, 2, 32'h4);
        model_clear();
    endtask

    task automatic test_flow(input int d, input int ncyc,
                             input int res, input bit rnd);
        bit rdy;
        run_to_fc(d);
        for (int c = 0; c < ncyc; c++) begin
            n_cmp++;
            if (w_valid !== (q.size() != 0)) begin
                n_bad++;
                $display("FAIL w_valid: got %b required %b",
                         w_valid, q.size() != 0);
            end
            if (q.size() != 0) begin
                n_cmp++;
                if (w_data !== q[0]) begin
                    n_bad++;
                    $display("FAIL w_data: got %h required %h",
                             w_data, q[0]);
                end
            end
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            w_ready = rdy;
            @(negedge clk);
            if (rdy && q.size() != 0) void'(q.pop_front());
        end
        w_ready = 0;
        fc_done = 1;
        fc_result = 24'(res);
        @(negedge clk);
        fc_done = 0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL done_state_busy: got %b required 1", busy);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL back_to_idle: got %b required 0", busy);
        end
        m_done = 1;
        m_result = 32'(res);
        check_regs("flow", 0);
    endtask

    task automatic test_full_flow();
        int res;
        test_flow(10, 4, -5, 0);
        for (int n = 0; n < 3; n++) begin
            res = int'($urandom_range(0, 24'hFFFFFF)) - 32'h800000;
            test_flow($urandom_range(1, 10), $urandom_range(0, 8), res, 1);
        end
    endtask

    task automatic test_busy_abort();
        wr(3'd0, 2, 32'h1);
        m_done = 0;
        wait_busy();
        wr(3'd0, 2, 32'h1);
        m_busy = 1;
        wr(3'd3, 1, $urandom);
        n_cmp++;
        if (buf_we !== 1'b0) begin
            n_bad++;
            $display("FAIL buf_we_busy: got %b required 0", buf_we);
        end
        conv_done = 1;
        @(negedge clk);
        conv_done = 0;
        n_cmp++;
        if (w_valid !== (q.size() != 0)) begin
            n_bad++;
            $display("FAIL fc_w_valid: got %b required %b",
                     w_valid, q.size() != 0);
        end
        wr(3'd0, 2, 32'h2);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_idle: got %b required 0", busy);
        end
        q.delete();
        m_abt = 1;
        check_regs("abort", 0);
    endtask

    task automatic test_abort_wins();
        wr(3'd0, 2, 32'h4);
        model_clear();
        for (int n = 0; n < 2; n++) begin
            logic [31:0] d;
            d = $urandom;
            wr(3'd7, 0, d);
            q.push_back(d);
        end
        run_to_fc(3);
        wr(3'd0, 2, 32'h2);
        fc_done = 1;
        fc_result = 24'($urandom);
        @(negedge clk);
        fc_done = 0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_wins_idle: got %b required 0", busy);
        end
        q.delete();
        m_abt = 1;
        check_regs("abort_wins", 0);
    endtask

    task automatic test_timeout();
        int cyc;
        wr(3'd0, 2, 32'h4);
        model_clear();
        for (int n = 0; n < 3; n++) begin
            logic [31:0] d;
            d = $urandom;
            wr(3'd7, 0, d);
            q.push_back(d);
        end
        wr(3'd0, 2, 32'h1);
        wait_busy();
        cyc = 1;
        while (busy && cyc < 40) begin
            @(negedge clk);
            if (busy) cyc++;
        end
        n_cmp++;
        if (cyc !== TO) begin
            n_bad++;
            $display("FAIL timeout_cycles: got %0d required %0d", cyc, TO);
        end
        q.delete();
        m_to = 1;
        check_regs("timeout", 0);
    endtask

    task automatic test_no_bypass();
        logic [31:0] d;
        int res;
        wr(3'd0, 2, 32'h4);
        model_clear();
        run_to_fc(2);
        d = $urandom;
        wr(3'd7, 0, d);
        n_cmp++;
        if (w_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL no_bypass: got %b required 0", w_valid);
        end
        q.push_back(d);
        @(negedge clk);
        n_cmp++;
        if ({w_valid, w_data} !== {1'b1, d}) begin
            n_bad++;
            $display("FAIL push_visible: got %b/%h required 1/%h",
                     w_valid, w_data, d);
        end
        res = int'($urandom_range(0, 24'hFFFFFF)) - 32'h800000;
        fc_done = 1;
        fc_result = 24'(res);
        @(negedge clk);
        fc_done = 0;
        @(negedge clk);
        m_done = 1;
        m_result = 32'(res);
        check_regs("no_bypass", 0);
    endtask

    task automatic test_reset_mid();
        wr(3'd7, 0, $urandom);
        wr(3'd0, 2, 32'h1);
        wait_busy();
        #2 rst = 1;
        #1;
        n_cmp++;
        if ({busy, conv_start, irq} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_mid: got %b required 000",
                     {busy, conv_start, irq});
        end
        @(negedge clk);
        rst = 0;
        q.delete();
        model_clear();
        m_result = '0;
        check_regs("reset_mid", 0);
    endtask

    initial begin
        test_reset();
        test_buf_write();
        test_fifo_overflow();
        test_full_flow();
        test_busy_abort();
        test_abort_wins();
        test_timeout();
        test_no_bypass();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
